uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler sharing one UART transmitter and its baud generator among N byte requesters, each of which may need a different baud rate. Per transfer it picks a winner, retunes the baud generator if the rate changes, and waits a settle period of `bclk` edges. It then issues a single-cycle start to the transmitter and holds ownership until the transmitter finishes. The block sits between the requesters and the `baudgen` / UART TX pair and is the only driver of `baudsel`.

## Interface
- `N`, 4 — number of requesters (2..8)
- `SETTLE`, 2 — `bclk` rising edges to wait after a baud change before starting TX (1..15)
- `BUSY_TO`, 64 — `clk` cycles allowed for `tx_busy` to rise after `tx_start`
- `BAUD_INIT`, 2'd1 — `baudsel` value after reset
- `clk` in 1 — system clock
- `rstb` in 1 — synchronous, active-high reset
- `req` in N — per-requester transfer request, level; held until `gnt`
- `req_baud` in 2N — per-requester baud select; slice i = bits [2i+1:2i]
- `req_data` in 8N — per-requester byte; slice i = bits [8i+7:8i]
- `gnt` out N — one-hot single-cycle pulse; byte accepted
- `baudsel` out 2 — baud select to baudgen
- `bg_clr` out 1 — single-cycle pulse; restarts baudgen divider on rate change
- `bclk` in 1 — baud clock from baudgen, synchronous to `clk`
- `tx_start` out 1 — single-cycle start to UART TX
- `tx_data` out 8 — byte to UART TX; valid while `tx_start` is high and held until IDLE
- `tx_busy` in 1 — UART TX busy
- `owner` out clog2(N) — current/last owner index
- `busy` out 1 — high in every state except IDLE
- `err` out 1 — single-cycle pulse on busy timeout

## Operation
- States: IDLE, RECFG, SETTLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: when any `req` is high, select the winner round-robin, starting from `last+1` mod N. Latch the winner index, its data and its baud.
  - Latched baud == `baudsel` → START.
  - Otherwise → RECFG.
- RECFG (1 cycle): `baudsel` ← latched baud; `bg_clr`=1; settle counter ← 0; → SETTLE.
- SETTLE: count rising edges of `bclk`, detected against a registered copy of `bclk`. When the count reaches SETTLE → START.
- START (1 cycle):
  - If `req[owner]` is still high: `tx_start`=1 and `gnt[owner]`=1; `last` ← owner; → WAIT_BUSY.
  - If it has dropped: abort with no `tx_start` and no `gnt`; `last` is unchanged; `baudsel` keeps the new value; → IDLE.
- WAIT_BUSY: stay until `tx_busy`=1, then → WAIT_DONE. If BUSY_TO cycles elapse first: `err` pulses one cycle and the state → IDLE.
- WAIT_DONE: stay until `tx_busy`=0, then → IDLE. There is no timeout in this state.
- Any change to `req` or `req_data` after the latch in IDLE is ignored. The transfer uses the latched values.
- Reset values: state IDLE, `baudsel`=BAUD_INIT, `last`=N-1 (so requester 0 wins first), `owner`=0, counters 0, `bclk` history 0.
  - All pulse outputs (`gnt`, `bg_clr`, `tx_start`, `err`) are 0.
  - `tx_data`=0 and `busy`=0.
- Reset asserted in any state forces the reset values on the next edge. `baudsel` returns to BAUD_INIT without a `bg_clr` pulse.

## Timing
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- Same-baud path:
  - `req` is sampled high in IDLE at edge k.
  - `tx_start` and `gnt` are high during the cycle after edge k+1.
  - `tx_start` and `gnt` are never high in any other cycle.
- Baud-change path:
  - `bg_clr` and the new `baudsel` appear after edge k+1.
  - `tx_start` follows 1 cycle after the SETTLE-th detected `bclk` rising edge.
- A `bclk` edge in the same cycle as RECFG is not counted.
- Back-to-back transfers: after WAIT_DONE → IDLE, there is at least one IDLE cycle before the next START. The round-robin pointer advances only on a granted transfer.
- `gnt` pulse and `tx_start` are coincident.

## Structure
- `uart_pkg`: state enum, `baudsel_t` (2-bit), BAUD_INIT default, settle/timeout counter widths.
- Sub-module `rr_arbiter` (parameter N): inputs `req` and `last`; outputs a one-hot grant and its index. It is purely combinational and is instantiated once.
- The top level holds the FSM, latch registers, `bclk` edge detector and counters.

## Test plan
- Reset, then `req`=4'b0001 with `req_baud`[1:0]=1 (equals BAUD_INIT) → no `bg_clr`; `tx_start` and `gnt`=0001 two edges after the request; `tx_data` = `req_data`[7:0].
- `req`=4'b1111, all at baud 1; TX model holds busy 20 cycles per byte → grant order 0,1,2,3,0; exactly one `gnt` pulse per transfer.
- Requester 2 asks for baud 3 while `baudsel`=1 → `bg_clr` pulse with `baudsel`=3; `tx_start` only after 2 further `bclk` rising edges.
- Requester 1 drops `req` during SETTLE → no `tx_start` and no `gnt`; returns to IDLE; `baudsel` stays at the new value; the next winner is still requester 1 if it re-requests.
- TX model never raises busy → `err` pulses 64 cycles after `tx_start`; FSM returns to IDLE; the next request is served normally.
- `rstb` asserted in WAIT_DONE → next edge gives IDLE, `baudsel`=1, all pulses 0, `busy`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_pkg;

   // Scheduler FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StRecfg,
      StSettle,
      StStart,
      StWaitBusy,
      StWaitDone
   } state_t;

   // Baud select code driven to the baud generator.
   typedef logic [1:0] baudsel_t;

   localparam baudsel_t BAUD_INIT_DEF = 2'd1;

   // Settle counter width; covers settle counts up to 15.
   localparam int unsigned SETTLE_CW = 4;

   // Width of a counter that must hold values 0..maxval.
   function automatic int unsigned cnt_width(input int unsigned maxval);
      return (maxval < 2) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request after 'last' wins.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int unsigned IW = $clog2(N);

   logic [IW-1:0] j;

   // Walk from lowest priority (last itself) to highest (last+1) so the nearest request
   // overwrites any earlier candidate.
   always_comb begin
      gnt = '0;
      idx = '0;
      j   = '0;
      for (int k = int'(N); k >= 1; k--) begin
         j = IW'((int'(last) + k) % int'(N));
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter and baud generator among N requesters, retuning the baud
// rate per transfer and waiting for the generator to settle before starting the byte.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned SETTLE    = 2,
   parameter int unsigned BUSY_TO   = 64,
   parameter baudsel_t    BAUD_INIT = BAUD_INIT_DEF
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic [N-1:0]         req,
   input  logic [2*N-1:0]       req_baud,
   input  logic [8*N-1:0]       req_data,
   output logic [N-1:0]         gnt,
   output logic [1:0]           baudsel,
   output logic                 bg_clr,
   input  logic                 bclk,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 err
);

   localparam int unsigned IW  = $clog2(N);
   localparam int unsigned TOW = cnt_width(BUSY_TO);

   state_t                state_q, state_d;
   baudsel_t              baudsel_q, baudsel_d;
   baudsel_t              baud_q, baud_d;
   logic [IW-1:0]         last_q, last_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [7:0]            data_q, data_d;
   logic [SETTLE_CW-1:0]  settle_q, settle_d;
   logic [SETTLE_CW-1:0]  settle_inc;
   logic [TOW-1:0]        to_q, to_d;
   logic                  bclk_q;
   logic                  bclk_rise;
   logic [N-1:0]          gnt_q, gnt_d;
   logic                  tx_start_q, tx_start_d;
   logic                  bg_clr_q, bg_clr_d;
   logic                  err_q, err_d;

   logic [N-1:0]          arb_gnt;
   logic [IW-1:0]         arb_idx;
   logic                  arb_valid;
   baudsel_t              win_baud;
   logic [7:0]            win_data;

   rr_arbiter #(
      .N(N)
   ) u_arb (
      .req  (req),
      .last (last_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   assign arb_valid  = |arb_gnt;
   assign win_baud   = req_baud[2*arb_idx +: 2];
   assign win_data   = req_data[8*arb_idx +: 8];
   assign bclk_rise  = bclk & ~bclk_q;
   assign settle_inc = settle_q + 1'b1;

   // Next-state and registered-output decode for the scheduler FSM.
   always_comb begin
      state_d    = state_q;
      baudsel_d  = baudsel_q;
      baud_d     = baud_q;
      last_d     = last_q;
      owner_d    = owner_q;
      data_d     = data_q;
      settle_d   = settle_q;
      to_d       = to_q;
      gnt_d      = '0;
      tx_start_d = 1'b0;
      bg_clr_d   = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               owner_d = arb_idx;
               data_d  = win_data;
               baud_d  = win_baud;
               state_d = (win_baud == baudsel_q) ? StStart : StRecfg;
            end
         end
         StRecfg: begin
            baudsel_d = baud_q;
            bg_clr_d  = 1'b1;
            settle_d  = '0;
            state_d   = StSettle;
         end
         StSettle: begin
            if (bclk_rise) begin
               settle_d = settle_inc;
               if (settle_inc == SETTLE_CW'(SETTLE)) begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            // A requester that gave up while we retuned forfeits the slot; the pointer
            // stays put so it wins again if it comes back.
            if (req[owner_q]) begin
               tx_start_d     = 1'b1;
               gnt_d[owner_q] = 1'b1;
               last_d         = owner_q;
               to_d           = '0;
               state_d        = StWaitBusy;
            end else begin
               state_d = StIdle;
            end
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end else if (to_q == TOW'(BUSY_TO - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, latch and pulse registers; reset is synchronous and active-high.
   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q    <= StIdle;
         baudsel_q  <= BAUD_INIT;
         baud_q     <= BAUD_INIT;
         last_q     <= IW'(N - 1);
         owner_q    <= '0;
         data_q     <= '0;
         settle_q   <= '0;
         to_q       <= '0;
         bclk_q     <= 1'b0;
         gnt_q      <= '0;
         tx_start_q <= 1'b0;
         bg_clr_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baudsel_q  <= baudsel_d;
         baud_q     <= baud_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         data_q     <= data_d;
         settle_q   <= settle_d;
         to_q       <= to_d;
         bclk_q     <= bclk;
         gnt_q      <= gnt_d;
         tx_start_q <= tx_start_d;
         bg_clr_q   <= bg_clr_d;
         err_q      <= err_d;
      end
   end

   assign gnt      = gnt_q;
   assign baudsel  = baudsel_q;
   assign bg_clr   = bg_clr_q;
   assign tx_start = tx_start_q;
   assign tx_data  = data_q;
   assign owner    = owner_q;
   assign busy     = (state_q != StIdle);
   assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table-driven single transfers plus hand-written
// sequences, with a scoreboard of expected (owner, byte) pairs popped on every tx_start.
module tb_uart_tx_sched;

   localparam int BDIV = 6;

   logic       clk;
   logic       rstb;
   logic [3:0] req;
   logic [7:0] req_baud;
   logic [31:0] req_data;
   logic [3:0] gnt;
   logic [1:0] baudsel;
   logic       bg_clr;
   logic       bclk;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic [1:0] owner;
   logic       busy;
   logic       err;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      int         idx;
      logic [1:0] baud;
      logic [7:0] data;
      bit         exp_clr;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[4];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int tx_cnt = 0;
   int gnt_cnt = 0;
   int bg_clr_cnt = 0;
   int err_cnt = 0;
   int rises = 0;
   int rises_at_clr = 0;
   int last_rise_cyc = 0;
   int tx_cyc = 0;
   int err_cyc = 0;
   logic err_busy = 1'b1;
   bit idle_seen = 1'b0;
   bit bclk_prev = 1'b0;
   bit no_busy = 1'b0;
   int busy_len = 20;

   uart_tx_sched dut (
      .clk      (clk),
      .rstb     (rstb),
      .req      (req),
      .req_baud (req_baud),
      .req_data (req_data),
      .gnt      (gnt),
      .baudsel  (baudsel),
      .bg_clr   (bg_clr),
      .bclk     (bclk),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .owner    (owner),
      .busy     (busy),
      .err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no_finish required finish");
      $fatal(1, "watchdog expired");
   end

   // Baud clock: one-cycle high pulse every BDIV clocks.
   initial begin
      bclk = 1'b0;
      forever begin
         repeat (BDIV - 1) @(posedge clk);
         #1 bclk = 1'b1;
         @(posedge clk);
         #1 bclk = 1'b0;
      end
   end

   // UART TX model: busy one cycle after tx_start, held busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && !no_busy) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [7:0] d);
      exp_t e;
      e.idx  = idx;
      e.data = d;
      sb.push_back(e);
   endtask

   // Monitor: edge/pulse bookkeeping and scoreboard pop on each start.
   initial begin
      exp_t e;
      bit   rise;
      forever begin
         @(negedge clk);
         rise      = bclk && !bclk_prev;
         bclk_prev = bclk;
         if (rise) begin
            rises++;
            last_rise_cyc = cyc;
         end
         if (busy === 1'b0) idle_seen = 1'b1;
         if (bg_clr === 1'b1) begin
            bg_clr_cnt++;
            rises_at_clr = rise ? rises - 1 : rises;
         end
         if (err === 1'b1) begin
            err_cnt++;
            err_cyc  = cyc;
            err_busy = busy;
         end
         if (tx_start === 1'b1 || gnt !== 4'b0) begin
            if (gnt !== 4'b0) gnt_cnt++;
            if (tx_start === 1'b1) tx_cnt++;
            tx_cyc = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_start", {28'b0, gnt}, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("gnt_onehot", {28'b0, gnt}, 32'(4'b0001 << e.idx));
               chk("tx_start_with_gnt", {31'b0, tx_start}, 32'h1);
               chk("tx_data", {24'b0, tx_data}, {24'b0, e.data});
               chk("owner", {30'b0, owner}, 32'(e.idx));
               chk("idle_before_start", {31'b0, idle_seen}, 32'h1);
            end
            idle_seen = 1'b0;
            req = req & ~gnt;
         end
      end
   end

   task automatic reset_check(input string tag);
      @(negedge clk);
      rstb = 1'b1;
      req  = 4'b0;
      @(negedge clk);
      chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
      chk({tag, "_baudsel"}, {30'b0, baudsel}, 32'h1);
      chk({tag, "_gnt"}, {28'b0, gnt}, 32'h0);
      chk({tag, "_tx_start"}, {31'b0, tx_start}, 32'h0);
      chk({tag, "_bg_clr"}, {31'b0, bg_clr}, 32'h0);
      chk({tag, "_err"}, {31'b0, err}, 32'h0);
      chk({tag, "_tx_data"}, {24'b0, tx_data}, 32'h0);
      chk({tag, "_owner"}, {30'b0, owner}, 32'h0);
      rstb = 1'b0;
   endtask

   task automatic wait_tx_count(input int target, input string name);
      int n = 0;
      while (tx_cnt < target && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk(name, tx_cnt, target);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'b0, busy}, 32'h0);
   endtask

   initial begin
      int t0;
      int g0;
      int c0;
      int e0;
      int req_cyc;
      int n;
      rstb     = 1'b1;
      req      = 4'b0;
      req_baud = 8'b0;
      req_data = 32'b0;
      vecs[0] = '{0, 2'd1, 8'hA5, 1'b0};
      vecs[1] = '{2, 2'd3, 8'h3C, 1'b1};
      vecs[2] = '{3, 2'd3, 8'h5A, 1'b0};
      vecs[3] = '{1, 2'd0, 8'hC3, 1'b1};
      repeat (3) @(negedge clk);
      reset_check("rst0");

      // Single-requester transfers, same-baud and baud-change.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         req_baud[2*vecs[i].idx +: 2] = vecs[i].baud;
         req_data[8*vecs[i].idx +: 8] = vecs[i].data;
         push_exp(vecs[i].idx, vecs[i].data);
         c0      = bg_clr_cnt;
         t0      = tx_cnt;
         req_cyc = cyc;
         req[vecs[i].idx] = 1'b1;
         wait_tx_count(t0 + 1, "row_tx");
         chk("row_bg_clr", bg_clr_cnt - c0, 32'(vecs[i].exp_clr));
         chk("row_baudsel", {30'b0, baudsel}, {30'b0, vecs[i].baud});
         if (vecs[i].exp_clr) begin
            chk("row_settle_rises", rises - rises_at_clr, 2);
            chk("row_rise_to_start", tx_cyc - last_rise_cyc, 2);
         end else begin
            chk("row_latency", tx_cyc - req_cyc, 2);
         end
         wait_idle("row_idle");
      end

      // Round robin from reset: 0,1,2,3 then 0 again.
      reset_check("rst1");
      req_baud = 8'b01010101;
      req_data = 32'h13121110;
      push_exp(0, 8'h10);
      push_exp(1, 8'h11);
      push_exp(2, 8'h12);
      push_exp(3, 8'h13);
      push_exp(0, 8'h10);
      t0 = tx_cnt;
      g0 = gnt_cnt;
      c0 = bg_clr_cnt;
      @(negedge clk);
      req = 4'b1111;
      n = 0;
      while (gnt_cnt < g0 + 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      req[0] = 1'b1;
      wait_tx_count(t0 + 5, "rr_tx_count");
      chk("rr_gnt_count", gnt_cnt - g0, 5);
      chk("rr_no_bg_clr", bg_clr_cnt - c0, 0);
      wait_idle("rr_idle");

      // Requester 1 retunes to baud 2, then drops its request while settling.
      t0 = tx_cnt;
      g0 = gnt_cnt;
      c0 = bg_clr_cnt;
      req_baud[3:2] = 2'd2;
      req_data[15:8] = 8'h42;
      @(negedge clk);
      req[1] = 1'b1;
      n = 0;
      while (bg_clr_cnt == c0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_bg_clr", bg_clr_cnt - c0, 1);
      req[1] = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_tx", tx_cnt - t0, 0);
      chk("abort_no_gnt", gnt_cnt - g0, 0);
      chk("abort_idle", {31'b0, busy}, 32'h0);
      chk("abort_baudsel", {30'b0, baudsel}, 32'h2);
      req_baud[5:4] = 2'd2;
      req_data[23:16] = 8'h24;
      push_exp(1, 8'h42);
      push_exp(2, 8'h24);
      req = 4'b0110;
      wait_tx_count(t0 + 2, "rerequest_tx_count");
      chk("rerequest_no_bg_clr", bg_clr_cnt - c0, 1);
      wait_idle("rerequest_idle");

      // TX never goes busy: timeout error, then a normal transfer.
      no_busy = 1'b1;
      t0 = tx_cnt;
      e0 = err_cnt;
      req_baud[7:6] = 2'd2;
      req_data[31:24] = 8'h77;
      push_exp(3, 8'h77);
      @(negedge clk);
      req[3] = 1'b1;
      wait_tx_count(t0 + 1, "to_tx");
      n = 0;
      while (err_cnt == e0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("to_err_pulses", err_cnt - e0, 1);
      chk("to_err_delay", err_cyc - tx_cyc, 64);
      chk("to_idle_at_err", {31'b0, err_busy}, 32'h0);
      no_busy = 1'b0;
      req_baud[1:0] = 2'd2;
      req_data[7:0] = 8'h99;
      push_exp(0, 8'h99);
      req[0] = 1'b1;
      wait_tx_count(t0 + 2, "after_to_tx");
      wait_idle("after_to_idle");

      // Reset while the transmitter is busy.
      t0 = tx_cnt;
      req_data[23:16] = 8'h66;
      push_exp(2, 8'h66);
      @(negedge clk);
      req[2] = 1'b1;
      wait_tx_count(t0 + 1, "wd_tx");
      n = 0;
      while (tx_busy !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("wd_busy_before_reset", {31'b0, busy}, 32'h1);
      c0 = bg_clr_cnt;
      reset_check("rst_wd");
      repeat (30) @(negedge clk);
      chk("wd_no_bg_clr_after_reset", bg_clr_cnt - c0, 0);
      chk("wd_no_tx_after_reset", tx_cnt - t0, 1);
      chk("wd_idle_after_reset", {31'b0, busy}, 32'h0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
